// File: rtl/ms_pkg.sv
// ms_pkg: constants and helpers shared by the MS token interface blocks.
//   - DEFAULT_FLUX / DEFAULT_DATA_WIDTH : default lane count and payload width
//   - clog2_min1()                       : tag width for a given lane count, minimum 1
//   - tag_lsb() / tag_msb() / payload_msb(): field positions inside a token.
//     The tag lives in the MSBs and the payload in the LSBs, matching the MS producers.
package ms_pkg;

    localparam int DEFAULT_FLUX       = 2;
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Ceiling log2 that never returns 0, so a tag field always exists.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int tag_lsb(input int data_width);
        return data_width;
    endfunction

    function automatic int tag_msb(input int data_width, input int tag_width);
        return data_width + tag_width - 1;
    endfunction

    function automatic int payload_msb(input int data_width);
        return data_width - 1;
    endfunction

endpackage

// File: rtl/ms_lane_fifo.sv
// ms_lane_fifo: one lane of the tag demux. A small circular FIFO with a registered
// push-style output port.
//   clk, rst (async, active-low)
//   push, push_data : store push_data this edge (ignored when full)
//   down_full       : downstream cannot take a token; the head is held
//   full            : count == DEPTH, taken from the registered count only
//   out_write       : registered; 1 for one cycle per emitted token
//   out_data        : registered head entry; holds its value when out_write=0
//
// Port protocol (write/full, push style): the producer raises write for one cycle
// per token; a token offered while full=1 is not stored. full is derived only from
// registered state, so a pop in the same cycle never makes room for a push.
module ms_lane_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  down_full,
    output logic                  full,
    output logic                  out_write,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  push_ok;
    logic                  pop;

    assign full    = (count == DEPTH_C);
    assign push_ok = push && !full;
    assign pop     = (count != '0) && !down_full;

    // Storage has no reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_write <= 1'b0;
            out_data  <= '0;
        end else begin
            out_write <= pop;
            if (pop) begin
                out_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;   // DEPTH is a power of two: wraps naturally
            end
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ms_tag_demux.sv
// ms_tag_demux: steers a tagged MS token stream into FLUX independent lane FIFOs.
//   clk, rst (async, active-low)
//   in_port_write/in_port_datain : tagged input token (tag in MSBs)
//   in_port_full                 : per-lane full flags returned upstream
//   out_port_write/dataout/full  : FLUX push-style output ports, tag stripped
//   err_overflow                 : sticky, a token was offered to a full lane
//   err_bad_tag                  : sticky, a token carried a tag >= FLUX
module ms_tag_demux
    import ms_pkg::*;
#(
    parameter int FLUX       = DEFAULT_FLUX,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int TAG_WIDTH  = clog2_min1(FLUX),
    parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_port_write,
    input  logic [WIDTH-1:0]           in_port_datain,
    output logic [FLUX-1:0]            in_port_full,
    output logic [FLUX-1:0]            out_port_write,
    output logic [FLUX*DATA_WIDTH-1:0] out_port_dataout,
    input  logic [FLUX-1:0]            out_port_full,
    output logic                       err_overflow,
    output logic                       err_bad_tag
);

    localparam int TAG_LO = tag_lsb(DATA_WIDTH);
    localparam int TAG_HI = tag_msb(DATA_WIDTH, TAG_WIDTH);
    localparam int PAY_HI = payload_msb(DATA_WIDTH);

    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] payload;
    logic                  tag_ok;
    logic [FLUX-1:0]       lane_hit;
    logic [FLUX-1:0]       lane_full;

    assign tag     = in_port_datain[TAG_HI:TAG_LO];
    assign payload = in_port_datain[PAY_HI:0];

    // Every tag value is a real lane when FLUX fills the tag space exactly.
    generate
        if ((1 << TAG_WIDTH) == FLUX) begin : g_tag_dense
            assign tag_ok = 1'b1;
        end else begin : g_tag_sparse
            localparam logic [TAG_WIDTH:0] FLUX_C = (TAG_WIDTH + 1)'(FLUX);
            assign tag_ok = ({1'b0, tag} < FLUX_C);
        end
    endgenerate

    for (genvar i = 0; i < FLUX; i++) begin : g_lane
        localparam logic [TAG_WIDTH-1:0] LANE = TAG_WIDTH'(i);

        assign lane_hit[i] = in_port_write && tag_ok && (tag == LANE);

        ms_lane_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .push      (lane_hit[i]),
            .push_data (payload),
            .down_full (out_port_full[i]),
            .full      (lane_full[i]),
            .out_write (out_port_write[i]),
            .out_data  (out_port_dataout[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign in_port_full = lane_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_overflow <= 1'b0;
            err_bad_tag  <= 1'b0;
        end else begin
            if (|(lane_hit & lane_full))   err_overflow <= 1'b1;
            if (in_port_write && !tag_ok)  err_bad_tag  <= 1'b1;
        end
    end

endmodule

// File: doc/ms_tag_demux.md
Name: ms_tag_demux

Overview:
Receiving end of the tagged multi-stream (MS) token interface produced by the SDF multi-flux wrappers. It accepts one tagged token stream and steers each token by its tag into one of FLUX per-lane FIFOs. Each lane presents a push-style write/full output port. Per-lane full flags are returned upstream so an MS producer can stall individual flows.

Parameters:
FLUX, 2, number of flows/lanes (>=2)
DATA_WIDTH, 8, payload bits per token
TAG_WIDTH, $clog2(FLUX), tag bits; forced to at least 1
WIDTH, DATA_WIDTH+TAG_WIDTH, input token width
DEPTH, 4, entries per lane FIFO (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
in_port_write  in  1  input token valid this cycle
in_port_datain  in  WIDTH  token; tag = [WIDTH-1:DATA_WIDTH], payload = [DATA_WIDTH-1:0]
in_port_full  out  FLUX  bit i = lane i cannot accept a token
out_port_write  out  FLUX  bit i = lane i presents a token this cycle
out_port_dataout  out  FLUX*DATA_WIDTH  lane i payload at [i*DATA_WIDTH +: DATA_WIDTH]; tag stripped
out_port_full  in  FLUX  bit i = downstream of lane i is full
err_overflow  out  1  sticky: a token was written to a full lane
err_bad_tag  out  1  sticky: a token carried tag >= FLUX

Behaviour:
- Reset (rst=0, async): all lane counts and pointers 0; out_port_write=0; out_port_dataout=0; err_* = 0; in_port_full=0 (derived from counts). Writes are ignored while rst=0.
- Lane FIFO: count register 0..DEPTH. in_port_full[i] = (count_i == DEPTH), driven combinationally from the registered count only.
- Push: on a clk edge with in_port_write=1 and tag t<FLUX:
  - If in_port_full[t]=0, store the payload in lane t.
  - Otherwise, drop the token and set err_overflow.
  - A pop on lane t in the same cycle does not rescue a write to a full lane; the full flag is conservative.
- Bad tag: tag >= FLUX (possible only for non-power-of-two FLUX) -> token dropped, err_bad_tag set, no lane touched.
- Pop/emit: each cycle, for each lane i, if count_i>0 and out_port_full[i]=0:
  - Register out_port_write[i]=1 and out_port_dataout lane i = head entry.
  - Advance the read pointer and decrement the count.
  - Otherwise, register out_port_write[i]=0.
  - Dataout holds its last value when write=0.
- Latency: token accepted at edge N appears with out_port_write=1 after edge N+1. Empty-lane push then pop is 1 cycle; no bypass path.
- Simultaneous push and pop on the same lane: count unchanged, both pointers advance. Full and empty are never both true.
- Pointers wrap modulo DEPTH. Lanes are fully independent, and order within a lane is preserved.
- Lane i backpressure (out_port_full[i]=1) never affects other lanes.
- Reset mid-operation: all queued tokens discarded, outputs return to reset values immediately (async). First token after release is handled per the normal rules.
- err_overflow and err_bad_tag clear only on reset.

Decomposition:
- Shared package ms_pkg holds:
  - clog2-with-minimum-1 function for TAG_WIDTH
  - tag-field and payload-field slice helpers/constants, keeping tag-in-MSBs placement consistent with the MS producers
  - default FLUX/DATA_WIDTH constants
- One sub-module, ms_lane_fifo (DATA_WIDTH, DEPTH), instantiated FLUX times via generate. It provides push, pop-when-not-downstream-full, registered write/data output, and count-based full.
- Top level contains only tag decode, drop/error logic and port packing.

Test Plan:
- Reset then tokens 0x0A5, 0x13C (FLUX=2, DATA_WIDTH=8) on consecutive cycles -> lane0 emits A5 one cycle after acceptance, lane1 emits 3C one cycle after its acceptance; no errors.
- Hold out_port_full[0]=1, write 0x001..0x004 -> in_port_full[0]=1 after the 4th. A 5th write 0x005 is dropped and err_overflow=1. Release -> lane0 emits 01,02,03,04 on consecutive cycles; 05 never appears.
- Lane1 stalled and full while lane0 streams 0x010..0x017 -> lane0 emits 10..17 in order at one token per cycle; in_port_full=2'b10 throughout.
- Lane0 with count=3, push and pop in the same cycle for 10 cycles -> count stays 3, in_port_full[0] never asserts, FIFO order preserved across pointer wrap.
- FLUX=3 (TAG_WIDTH=2), write tag 3 token 0x3FF -> no lane emits, err_bad_tag=1.
- Assert rst=0 mid-stream with lane0 holding 3 tokens -> out_port_write=0 and in_port_full=0 immediately. After release, new token 0x0EE emits EE first.
